hazard_ctl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage core. It watches the ID and EX stages and drives the PC, IF_ID and ID_EX enables and flushes. Three hazards are handled: load-use stalls, taken-branch/jump flushes, and structural stalls while the multi-cycle mult/div unit next to the EX-stage ALU is busy. It also owns the mult/div sequencing FSM and a saturating stall-cycle counter.

---
 rtl/hazard_if.sv | 37 +++
 rtl/hazard_ctl.sv | 126 ++++++++++++
 tb/tb_hazard_ctl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// hazard_if: ID/EX hazard inputs and pipeline-control outputs of the hazard controller.
//   slave  : hazard_ctl side (observes ID/EX fields, drives enables/flushes and mult/div status)
//   master : pipeline side (drives ID/EX fields, receives enables/flushes and mult/div status)
interface hazard_if;
   logic [4:0]  ID_Rs;
   logic [4:0]  ID_Rt;
   logic        ID_UsesRs;
   logic        ID_UsesRt;
   logic        ID_UsesHiLo;
   logic        ID_Jump;
   logic        EX_MemRead;
   logic [4:0]  EX_WriteRegister;
   logic        EX_BranchTaken;
   logic [1:0]  EX_MulDivOp;
   logic        PC_Write;
   logic        IF_ID_Write;
   logic        IF_ID_Flush;
   logic        ID_EX_Flush;
   logic        MulDiv_Start;
   logic        MulDiv_Busy;
   logic        MulDiv_Done;
   logic [15:0] Stall_Count;

   modport slave (
      input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_UsesHiLo, ID_Jump,
             EX_MemRead, EX_WriteRegister, EX_BranchTaken, EX_MulDivOp,
      output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
             MulDiv_Start, MulDiv_Busy, MulDiv_Done, Stall_Count
   );

   modport master (
      output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_UsesHiLo, ID_Jump,
             EX_MemRead, EX_WriteRegister, EX_BranchTaken, EX_MulDivOp,
      input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
             MulDiv_Start, MulDiv_Busy, MulDiv_Done, Stall_Count
   );
endinterface

// File: rtl/hazard_ctl.sv
// hazard_ctl: pipeline hazard controller for the 5-stage core.
//   clk, rst_n : clock and asynchronous active-low reset
//   hz         : hazard_if.slave
//                in : ID source regs/usage, ID jump, EX load/dest, EX branch, EX mult/div op
//                out: PC/IF_ID enables and flushes (combinational, same-cycle effect),
//                     mult/div start/busy/done, saturating stall-cycle counter
module hazard_ctl #(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   hazard_if.slave  hz
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = (MAX_CYCLES >= 2) ? $clog2(MAX_CYCLES) : 1;
   localparam int unsigned SC_W       = 16;

   localparam logic [1:0] OP_MULT = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;

   logic muldiv_req_c;
   logic start_c;
   logic load_use_c;
   logic hilo_stall_c;
   logic stall_c;

   // Reserved op encoding 11 behaves like no op.
   assign muldiv_req_c = (hz.EX_MulDivOp == OP_MULT) || (hz.EX_MulDivOp == OP_DIV);

   // Mult/div sequencer: next state, cycle counter and start pulse.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (muldiv_req_c) begin
               start_c = 1'b1;
               cnt_d   = (hz.EX_MulDivOp == OP_MULT) ? CNT_W'(MULT_CYCLES - 1)
                                                     : CNT_W'(DIV_CYCLES - 1);
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Hazard detection; a load into $0 never creates a dependency.
   always_comb begin
      load_use_c = hz.EX_MemRead && (hz.EX_WriteRegister != 5'd0) &&
                   ((hz.ID_UsesRs && (hz.ID_Rs == hz.EX_WriteRegister)) ||
                    (hz.ID_UsesRt && (hz.ID_Rt == hz.EX_WriteRegister)));
      // HI/LO users wait from the start cycle until the DONE cycle.
      hilo_stall_c = hz.ID_UsesHiLo && (start_c || (state_q == ST_BUSY));
      stall_c      = load_use_c || hilo_stall_c;
   end

   // Pipeline control with priority: taken branch, stall, jump.
   always_comb begin
      hz.PC_Write    = 1'b1;
      hz.IF_ID_Write = 1'b1;
      hz.IF_ID_Flush = 1'b0;
      hz.ID_EX_Flush = 1'b0;
      if (hz.EX_BranchTaken) begin
         hz.IF_ID_Flush = 1'b1;
         hz.ID_EX_Flush = 1'b1;
      end else if (stall_c) begin
         hz.PC_Write    = 1'b0;
         hz.IF_ID_Write = 1'b0;
         hz.ID_EX_Flush = 1'b1;
      end else if (hz.ID_Jump) begin
         hz.IF_ID_Flush = 1'b1;
      end
   end

   // Stall counter saturates at all-ones; branch-suppressed stalls do not count.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_c && !hz.EX_BranchTaken && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + SC_W'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.MulDiv_Start = start_c;
   assign hz.MulDiv_Busy  = (state_q == ST_BUSY);
   assign hz.MulDiv_Done  = (state_q == ST_DONE);
   assign hz.Stall_Count  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl: directed literal checks plus randomized stimulus compared every cycle
// against a timeline-based behavioural model of the hazard controller.
module tb_hazard_ctl;

   localparam int MULT_N = 4;
   localparam int DIV_N  = 32;

   logic clk;
   logic rst_n;

   hazard_if hif ();

   hazard_ctl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: an op is described by its start cycle and length; all outputs follow from
   // the distance between the current cycle and that start cycle.
   int cyc     = 0;
   int op_t    = -1;
   int op_n    = 0;
   int m_scnt  = 0;

   always @(negedge clk) begin : model
      bit idle, busy, done, start, lu, hs, st;
      int e_pc, e_ifw, e_iff, e_idf;
      if (!rst_n) begin
         op_t   = -1;
         m_scnt = 0;
      end
      if (op_t >= 0 && cyc >= op_t + op_n + 2) op_t = -1;
      idle  = (op_t < 0);
      busy  = !idle && (cyc >= op_t + 1) && (cyc <= op_t + op_n);
      done  = !idle && (cyc == op_t + op_n + 1);
      start = idle && (hif.EX_MulDivOp == 2'd1 || hif.EX_MulDivOp == 2'd2);
      lu = hif.EX_MemRead && hif.EX_WriteRegister != 0 &&
           ((hif.ID_UsesRs && hif.ID_Rs == hif.EX_WriteRegister) ||
            (hif.ID_UsesRt && hif.ID_Rt == hif.EX_WriteRegister));
      hs = hif.ID_UsesHiLo && (start || busy);
      st = lu || hs;
      if (hif.EX_BranchTaken) begin
         e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 1;
      end else if (st) begin
         e_pc = 0; e_ifw = 0; e_iff = 0; e_idf = 1;
      end else if (hif.ID_Jump) begin
         e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 0;
      end else begin
         e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0;
      end
      chk("m_pc_write",  int'(hif.PC_Write),     e_pc);
      chk("m_ifid_wr",   int'(hif.IF_ID_Write),  e_ifw);
      chk("m_ifid_fl",   int'(hif.IF_ID_Flush),  e_iff);
      chk("m_idex_fl",   int'(hif.ID_EX_Flush),  e_idf);
      chk("m_start",     int'(hif.MulDiv_Start), int'(start));
      chk("m_busy",      int'(hif.MulDiv_Busy),  int'(busy));
      chk("m_done",      int'(hif.MulDiv_Done),  int'(done));
      chk("m_stall_cnt", int'(hif.Stall_Count),  m_scnt);
      // Effect of the coming rising edge.
      if (rst_n) begin
         if (start) begin
            op_t = cyc;
            op_n = (hif.EX_MulDivOp == 2'd1) ? MULT_N : DIV_N;
         end
         if (st && !hif.EX_BranchTaken && m_scnt < 65535) m_scnt++;
      end
      cyc++;
   end

   task automatic clr();
      hif.ID_Rs = 5'd0;  hif.ID_Rt = 5'd0;
      hif.ID_UsesRs = 1'b0; hif.ID_UsesRt = 1'b0;
      hif.ID_UsesHiLo = 1'b0; hif.ID_Jump = 1'b0;
      hif.EX_MemRead = 1'b0; hif.EX_WriteRegister = 5'd0;
      hif.EX_BranchTaken = 1'b0; hif.EX_MulDivOp = 2'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load_use(input logic [4:0] rd);
      hif.EX_MemRead = 1'b1;
      hif.EX_WriteRegister = rd;
      hif.ID_Rs = rd;
      hif.ID_UsesRs = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      clr();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pc",    int'(hif.PC_Write),     1);
      chk("rst_ifw",   int'(hif.IF_ID_Write),  1);
      chk("rst_iff",   int'(hif.IF_ID_Flush),  0);
      chk("rst_idf",   int'(hif.ID_EX_Flush),  0);
      chk("rst_busy",  int'(hif.MulDiv_Busy),  0);
      chk("rst_done",  int'(hif.MulDiv_Done),  0);
      chk("rst_start", int'(hif.MulDiv_Start), 0);
      chk("rst_cnt",   int'(hif.Stall_Count),  0);
      tick();
      rst_n = 1'b1;

      // Load-use: exactly one bubble.
      set_load_use(5'd8);
      @(negedge clk);
      chk("lu_pc",  int'(hif.PC_Write),    0);
      chk("lu_ifw", int'(hif.IF_ID_Write), 0);
      chk("lu_idf", int'(hif.ID_EX_Flush), 1);
      tick();
      clr();
      @(negedge clk);
      chk("lu_after_pc",  int'(hif.PC_Write),    1);
      chk("lu_after_cnt", int'(hif.Stall_Count), 1);
      tick();

      // Load into $0 never stalls.
      set_load_use(5'd0);
      @(negedge clk);
      chk("r0_pc", int'(hif.PC_Write), 1);
      tick();

      // Taken branch overrides a load-use stall.
      set_load_use(5'd9);
      hif.EX_BranchTaken = 1'b1;
      @(negedge clk);
      chk("br_pc",  int'(hif.PC_Write),    1);
      chk("br_iff", int'(hif.IF_ID_Flush), 1);
      chk("br_idf", int'(hif.ID_EX_Flush), 1);
      tick();
      clr();
      @(negedge clk);
      chk("br_cnt", int'(hif.Stall_Count), 1);
      tick();

      // Jump held in ID behind a load-use stall.
      set_load_use(5'd5);
      hif.ID_Jump = 1'b1;
      @(negedge clk);
      chk("jh_iff", int'(hif.IF_ID_Flush), 0);
      chk("jh_pc",  int'(hif.PC_Write),    0);
      tick();
      hif.EX_MemRead = 1'b0;
      @(negedge clk);
      chk("jr_iff", int'(hif.IF_ID_Flush), 1);
      chk("jr_pc",  int'(hif.PC_Write),    1);
      chk("jr_idf", int'(hif.ID_EX_Flush), 0);
      tick();
      clr();

      // Mult with mfhi waiting in ID; counter was 2 before.
      hif.EX_MulDivOp = 2'd1;
      hif.ID_UsesHiLo = 1'b1;
      @(negedge clk);
      chk("mu_start", int'(hif.MulDiv_Start), 1);
      chk("mu_ifw0",  int'(hif.IF_ID_Write),  0);
      tick();
      hif.EX_MulDivOp = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("mu_busy", int'(hif.MulDiv_Busy), 1);
         chk("mu_ifw",  int'(hif.IF_ID_Write), 0);
         tick();
      end
      @(negedge clk);
      chk("mu_done",  int'(hif.MulDiv_Done), 1);
      chk("mu_ifw5",  int'(hif.IF_ID_Write), 1);
      chk("mu_cnt",   int'(hif.Stall_Count), 7);
      tick();
      clr();
      @(negedge clk);
      chk("mu_idle", int'(hif.MulDiv_Done) + int'(hif.MulDiv_Busy), 0);
      tick();

      // Div with re-issued ops during BUSY: single Done at T+33.
      for (int k = 0; k <= 40; k++) begin
         hif.EX_MulDivOp = (k == 0 || k == 1 || k == 5) ? 2'd2 : 2'd0;
         @(negedge clk);
         chk("dv_done", int'(hif.MulDiv_Done), (k == 33) ? 1 : 0);
         chk("dv_busy", int'(hif.MulDiv_Busy), (k >= 1 && k <= 32) ? 1 : 0);
         tick();
      end
      clr();

      // Async reset two cycles into a div aborts it.
      hif.EX_MulDivOp = 2'd2;
      tick();
      hif.EX_MulDivOp = 2'd0;
      tick();
      #1 rst_n = 1'b0;
      #1;
      chk("ab_busy", int'(hif.MulDiv_Busy), 0);
      chk("ab_cnt",  int'(hif.Stall_Count), 0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         chk("ab_nodone", int'(hif.MulDiv_Done), 0);
         tick();
      end

      // Randomized traffic with occasional async resets.
      for (int k = 0; k < 3000; k++) begin
         hif.ID_Rs            = 5'($urandom_range(0, 3));
         hif.ID_Rt            = 5'($urandom_range(0, 3));
         hif.ID_UsesRs        = 1'($urandom_range(0, 1));
         hif.ID_UsesRt        = 1'($urandom_range(0, 1));
         hif.ID_UsesHiLo      = ($urandom % 4) == 0;
         hif.ID_Jump          = ($urandom % 8) == 0;
         hif.EX_MemRead       = ($urandom % 3) == 0;
         hif.EX_WriteRegister = 5'($urandom_range(0, 3));
         hif.EX_BranchTaken   = ($urandom % 8) == 0;
         hif.EX_MulDivOp      = (($urandom % 10) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         rst_n                = ($urandom % 500) != 0;
         tick();
      end
      rst_n = 1'b1;
      clr();

      // Saturation: fresh reset then a long forced stall.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_load_use(5'd3);
      repeat (70000) tick();
      @(negedge clk);
      chk("sat_cnt", int'(hif.Stall_Count), 65535);
      tick();
      @(negedge clk);
      chk("sat_hold", int'(hif.Stall_Count), 65535);
      tick();
      clr();
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
